// File: rtl/cmos_dvp_capture.sv
// rtl/cmos_dvp_capture.sv - DVP camera capture: byte-to-pixel assembly, frame gating, SOF/EOL markers
module cmos_dvp_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST     = 1,
  parameter int FRAME_WAITCNT = 15,
  parameter int CNT_W         = 12
) (
  input  logic                            cmos_pclk_i,
  input  logic                            rst_n_i,
  input  logic                            cmos_href_i,
  input  logic                            cmos_vsync_i,
  input  logic [DATA_W-1:0]               cmos_data_i,
  input  logic                            cap_en_i,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data_o,
  output logic                            pix_valid_o,
  output logic                            sof_o,
  output logic                            eol_o,
  output logic [CNT_W-1:0]                line_cnt_o,
  output logic [CNT_W-1:0]                pix_cnt_o,
  output logic [15:0]                     frame_cnt_o,
  output logic                            err_partial_o,
  output logic                            busy_o
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {ST_SKIP, ST_IDLE, ST_ACTIVE} state_t;
  localparam state_t RESET_ST = (FRAME_WAITCNT == 0) ? ST_IDLE : ST_SKIP;

  logic              href_q, vsync_q, href_d1_q, vsync_d1_q;
  logic [DATA_W-1:0] data_q;

  state_t            state_q, state_d;
  logic [7:0]        skip_cnt_q, skip_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [PIX_W-1:0]  asm_q, asm_d, asm_shift;
  logic [PIX_W-1:0]  hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              first_pix_q, first_pix_d;
  logic [CNT_W-1:0]  line_pix_q, line_pix_d;

  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic frame_start, frame_end, href_fall;

  assign frame_start = vsync_d1_q & ~vsync_q;
  assign frame_end   = ~vsync_d1_q & vsync_q;
  assign href_fall   = href_d1_q & ~href_q;

  // Value of the assembly register once the current byte is shifted in.
  generate
    if (BYTES_PER_PIX == 1) begin : g_one
      assign asm_shift = data_q;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign asm_shift = {asm_q[PIX_W-DATA_W-1:0], data_q};
    end else begin : g_lsb
      assign asm_shift = {data_q, asm_q[PIX_W-1:DATA_W]};
    end
  endgenerate

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      data_q      <= '0;
      href_d1_q   <= 1'b0;
      vsync_d1_q  <= 1'b0;
      state_q     <= RESET_ST;
      skip_cnt_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      first_pix_q <= 1'b0;
      line_pix_q  <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      err_q       <= 1'b0;
      line_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      href_q      <= cmos_href_i;
      vsync_q     <= cmos_vsync_i;
      data_q      <= cmos_data_i;
      href_d1_q   <= href_q;
      vsync_d1_q  <= vsync_q;
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      first_pix_q <= first_pix_d;
      line_pix_q  <= line_pix_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      err_q       <= err_d;
      line_cnt_q  <= line_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    first_pix_d = first_pix_q;
    line_pix_d  = line_pix_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    err_d       = 1'b0;
    line_cnt_d  = line_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_SKIP: begin
        if (frame_start) begin
          if (skip_cnt_q != 8'hFF) skip_cnt_d = skip_cnt_q + 8'd1;
          if (({1'b0, skip_cnt_q} + 9'd1) >= 9'(FRAME_WAITCNT)) state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (frame_start && cap_en_i) begin
          state_d     = ST_ACTIVE;
          first_pix_d = 1'b1;
          line_cnt_d  = '0;
          byte_idx_d  = '0;
          hold_vld_d  = 1'b0;
          line_pix_d  = '0;
        end
      end

      ST_ACTIVE: begin
        if (frame_end) begin
          if (hold_vld_q) begin
            pix_valid_d = 1'b1;
            pix_data_d  = hold_q;
            eol_d       = 1'b1;
            sof_d       = first_pix_q;
            first_pix_d = 1'b0;
          end
          hold_vld_d  = 1'b0;
          byte_idx_d  = '0;
          line_pix_d  = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end else if (href_q) begin
          asm_d = asm_shift;
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            line_pix_d = line_pix_q + 1'b1;
            hold_d     = asm_shift;
            hold_vld_d = 1'b1;
            // The held pixel is known not to end the line once a successor completes.
            if (hold_vld_q) begin
              pix_valid_d = 1'b1;
              pix_data_d  = hold_q;
              sof_d       = first_pix_q;
              first_pix_d = 1'b0;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          byte_idx_d = '0;
          if (href_fall) begin
            if (hold_vld_q) begin
              pix_valid_d = 1'b1;
              pix_data_d  = hold_q;
              eol_d       = 1'b1;
              sof_d       = first_pix_q;
              first_pix_d = 1'b0;
            end
            hold_vld_d = 1'b0;
            err_d      = (byte_idx_q != 2'd0);
            pix_cnt_d  = line_pix_q;
            line_pix_d = '0;
            if (line_cnt_q != {CNT_W{1'b1}}) line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = RESET_ST;
    endcase
  end

  assign pix_data_o    = pix_data_q;
  assign pix_valid_o   = pix_valid_q;
  assign sof_o         = sof_q;
  assign eol_o         = eol_q;
  assign err_partial_o = err_q;
  assign line_cnt_o    = line_cnt_q;
  assign pix_cnt_o     = pix_cnt_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign busy_o        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// tb/tb_cmos_dvp_capture.sv - directed bench: two capture instances (MSB/LSB first, skip 2/0 frames)
module tb_cmos_dvp_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       href, vsync, cap_en;
  logic [7:0] data;

  logic [15:0] a_data, b_data;
  logic        a_valid, a_sof, a_eol, a_err, a_busy;
  logic        b_valid, b_sof, b_eol, b_err, b_busy;
  logic [11:0] a_line, a_pix, b_line, b_pix;
  logic [15:0] a_frame, b_frame;

  always #5 clk = ~clk;

  cmos_dvp_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .MSB_FIRST(1), .FRAME_WAITCNT(2), .CNT_W(12)) dut_a (
    .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href), .cmos_vsync_i(vsync),
    .cmos_data_i(data), .cap_en_i(cap_en), .pix_data_o(a_data), .pix_valid_o(a_valid),
    .sof_o(a_sof), .eol_o(a_eol), .line_cnt_o(a_line), .pix_cnt_o(a_pix),
    .frame_cnt_o(a_frame), .err_partial_o(a_err), .busy_o(a_busy));

  cmos_dvp_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .MSB_FIRST(0), .FRAME_WAITCNT(0), .CNT_W(12)) dut_b (
    .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href), .cmos_vsync_i(vsync),
    .cmos_data_i(data), .cap_en_i(cap_en), .pix_data_o(b_data), .pix_valid_o(b_valid),
    .sof_o(b_sof), .eol_o(b_eol), .line_cnt_o(b_line), .pix_cnt_o(b_pix),
    .frame_cnt_o(b_frame), .err_partial_o(b_err), .busy_o(b_busy));

  logic [15:0] a_log[$];
  logic        a_eolq[$];
  logic        a_sofq[$];
  logic [15:0] b_log[$];
  int          a_errs = 0;

  always @(negedge clk) begin
    if (a_valid) begin
      a_log.push_back(a_data);
      a_eolq.push_back(a_eol);
      a_sofq.push_back(a_sof);
    end
    if (a_err) a_errs++;
    if (b_valid) b_log.push_back(b_data);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] base);
    for (int i = 0; i < nbytes; i++) begin
      href = 1'b1;
      data = base + 8'(8'h11 * i);
      tick(1);
    end
    href = 1'b0;
    data = 8'h00;
    tick(3);
  endtask

  task automatic send_frame(input int lines, input int nbytes, input logic [7:0] base, input int cap_mid);
    vsync = 1'b0;
    tick(3);
    for (int l = 0; l < lines; l++) begin
      send_line(nbytes, base);
      if (l == 0 && cap_mid >= 0) cap_en = cap_mid[0];
    end
    tick(2);
    vsync = 1'b1;
    tick(6);
  endtask

  task automatic check_frame(input string tag, input int ia, input int npix, input int neol, input int nsof);
    int ne, ns;
    ne = 0;
    ns = 0;
    check({tag, "_npix"}, a_log.size() - ia, npix);
    for (int i = ia; i < a_log.size(); i++) begin
      ne += int'(a_eolq[i]);
      ns += int'(a_sofq[i]);
    end
    check({tag, "_neol"}, ne, neol);
    check({tag, "_nsof"}, ns, nsof);
  endtask

  int ia, ib, e0;

  initial begin
    rst_n  = 1'b0;
    href   = 1'b0;
    vsync  = 1'b1;
    cap_en = 1'b1;
    data   = 8'h00;
    tick(3);
    check("rst_valid", a_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_frame", a_frame, 0);
    check("rst_line", a_line, 0);
    rst_n = 1'b1;
    tick(4);

    ia = a_log.size(); ib = b_log.size();
    send_frame(3, 8, 8'h10, -1);
    check("f1_a_npix", a_log.size() - ia, 0);
    check("f1_b_npix", b_log.size() - ib, 12);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check("f2_a_npix", a_log.size() - ia, 0);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check_frame("f3", ia, 12, 3, 1);
    check("f3_pix0", a_log[ia], 16'h1021);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check_frame("f4", ia, 12, 3, 1);
    check("f4_frame", a_frame, 2);
    check("f4_pixcnt", a_pix, 4);
    check("f4_linecnt", a_line, 3);
    check("f4_busy", a_busy, 0);

    ia = a_log.size(); ib = b_log.size(); e0 = a_errs;
    send_frame(1, 7, 8'hA1, -1);
    check_frame("f5", ia, 3, 1, 1);
    check("f5_msb_pix0", a_log[ia], 16'hA1B2);
    check("f5_pix2", a_log[ia+2], 16'hE5F6);
    check("f5_eol_last", a_eolq[ia+2], 1);
    check("f5_lsb_pix0", b_log[ib], 16'hB2A1);
    check("f5_err", a_errs - e0, 1);
    check("f5_pixcnt", a_pix, 3);
    check("f5_linecnt", a_line, 1);

    ia = a_log.size();
    send_frame(3, 8, 8'h10, 0);
    check_frame("f6", ia, 12, 3, 1);
    cap_en = 1'b1;
    tick(2);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check_frame("f7", ia, 12, 3, 1);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, 0);
    check_frame("f8", ia, 12, 3, 1);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check("f9_npix", a_log.size() - ia, 0);
    check("f9_frame", a_frame, 6);
    cap_en = 1'b1;

    ia = a_log.size();
    vsync = 1'b0;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) vsync = 1'b1;
      href = 1'b1;
      data = 8'h10 + 8'(8'h11 * i);
      tick(1);
      if (i == 1) check("f10_busy_mid", a_busy, 1);
    end
    href = 1'b0;
    tick(6);
    check("f10_npix", a_log.size() - ia, 2);
    check("f10_pix1", a_log[ia+1], 16'h3243);
    check("f10_eol", a_eolq[ia+1], 1);
    check("f10_frame", a_frame, 7);
    check("f10_busy", a_busy, 0);

    ia = a_log.size(); ib = b_log.size();
    vsync = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      data = 8'h10 + 8'(8'h11 * i);
      if (i == 3) begin
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", a_valid, 0);
        check("mrst_busy", a_busy, 0);
        check("mrst_frame", a_frame, 0);
        check("mrst_line", a_line, 0);
      end
      if (i == 5) rst_n = 1'b1;
      tick(1);
    end
    href = 1'b0;
    data = 8'h00;
    tick(3);
    send_line(8, 8'h10);
    send_line(8, 8'h10);
    tick(2);
    vsync = 1'b1;
    tick(6);
    check("rem_a_npix", a_log.size() - ia, 0);
    check("rem_b_npix", b_log.size() - ib, 0);
    ia = a_log.size(); ib = b_log.size();
    send_frame(3, 8, 8'h10, -1);
    check("fx_a_npix", a_log.size() - ia, 0);
    check("fx_b_npix", b_log.size() - ib, 12);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check("fy_a_npix", a_log.size() - ia, 0);
    ia = a_log.size();
    send_frame(3, 8, 8'h10, -1);
    check_frame("fz", ia, 12, 3, 1);
    check("fz_frame", a_frame, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
